serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter N_WIDTH, default 4, operand width in bits (N_WIDTH >= 2).
REQ-002 SHALL have parameter SIGNED, default 1; 1 means two's-complement operands, 0 means unsigned operands.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands a/b present.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port a, input, N_WIDTH, first operand.
REQ-008 SHALL have port b, input, N_WIDTH, second operand.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have ports gt, lt and eq, each output, 1, meaning a>b, a<b and a==b respectively.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL treat in_valid&&in_ready at a rising edge as operand capture: a/b registered, bit index set to N_WIDTH-1, undecided flag set, transition to SHIFT.
REQ-016 SHALL, in SHIFT, examine exactly one bit pair per cycle, MSB first, decrementing the index.
REQ-017 SHALL record the decision at the first differing bit pair and ignore all later bit pairs.
REQ-018 SHALL, at a differing MSB pair with SIGNED=1, decide a bit of 1 as the smaller operand; all other differing pairs decide a bit of 1 as the larger operand.
REQ-019 SHALL transition SHIFT->DONE on the edge that processes index 0, giving out_valid exactly N_WIDTH cycles after the capture edge.
REQ-020 SHALL set eq=1 only when no differing pair was found; exactly one of gt/lt/eq SHALL be 1 while out_valid=1.
REQ-021 SHALL force gt=lt=eq=0 whenever out_valid=0.
REQ-022 SHALL hold out_valid, gt, lt and eq stable in DONE until out_valid&&out_ready, then transition DONE->IDLE.
REQ-023 SHALL ignore a and b after capture; input changes during SHIFT or DONE SHALL NOT alter the result.
REQ-024 SHALL accept no new operands in the cycle of the output handshake; the next capture is possible at the earliest one cycle later.

Reset
REQ-025 SHALL, when rst_n is low, asynchronously force state IDLE, out_valid=0, gt=lt=eq=0, busy=0, in_ready=1, and clear the index and decision registers.
REQ-026 SHALL, on reset asserted mid-SHIFT or in DONE, discard the pending result without ever asserting out_valid for it.

Configuration
REQ-027 SHALL support macro SERIAL_CMP_EARLY_EXIT_EN.
REQ-028 SHALL, with SERIAL_CMP_EARLY_EXIT_EN defined, transition SHIFT->DONE on the edge that processes the first differing pair, giving latency (N_WIDTH - index_of_first_difference) cycles; equal operands still take N_WIDTH cycles.
REQ-029 SHALL, with SERIAL_CMP_EARLY_EXIT_EN undefined, have fixed latency N_WIDTH cycles for every operand pair.

Structure
REQ-030 SHALL place the FSM state enum and the 2-bit decision encoding (UNDEC, GT, LT) in shared package serial_comparator_pkg.
REQ-031 SHALL put per-bit decision logic (bit pair, is_msb, SIGNED, current decision -> next decision) in sub-module serial_cmp_bit_step.

Verification
REQ-032 SHALL verify: N_WIDTH=4, SIGNED=1, a=4'b1000, b=4'b0111 -> lt=1, gt=eq=0, out_valid 4 cycles after capture.
REQ-033 SHALL verify: SIGNED=0 with the same operands -> gt=1; a=b=4'd5 -> eq=1 after 4 cycles under both macro settings.
REQ-034 SHALL verify: unsigned a=4'd8, b=4'd0 -> out_valid after 1 cycle with SERIAL_CMP_EARLY_EXIT_EN defined, after 4 cycles without it.
REQ-035 SHALL verify: out_ready held low 3 cycles in DONE -> gt/lt/eq stable and in_ready=0 throughout; IDLE is entered on the edge where out_ready goes high.
REQ-036 SHALL verify: rst_n pulsed low during the 2nd SHIFT cycle -> out_valid=0, in_ready=1 immediately; a following transaction produces the correct result.
REQ-037 SHALL verify: exhaustive sweep of all a,b in [-8,7] (SIGNED=1) and in [0,15] (SIGNED=0) -> every result matches a signed or unsigned integer comparison of the same operands.

Source files
------------

// File: rtl/serial_comparator_pkg.sv
// -----------------------------------------------------------------------------
// serial_comparator_pkg
// Shared types for the bit-serial magnitude comparator:
//   state_e : controller states (IDLE, SHIFT, DONE)
//   dec_e   : 2-bit running decision (UNDEC, GT, LT)
//   dec_to_flags : maps a final decision onto the {gt, lt, eq} flag triple
// -----------------------------------------------------------------------------
package serial_comparator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      DEC_UNDEC = 2'd0,
      DEC_GT    = 2'd1,
      DEC_LT    = 2'd2
   } dec_e;

   // {gt, lt, eq}; a decision still undecided after the last bit means equal
   function automatic logic [2:0] dec_to_flags(input dec_e dec);
      logic [2:0] flags;
      case (dec)
         DEC_GT:  flags = 3'b100;
         DEC_LT:  flags = 3'b010;
         default: flags = 3'b001;
      endcase
      return flags;
   endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// -----------------------------------------------------------------------------
// serial_comparator_if
// Operand/result handshake bundle of the serial comparator.
//   in_valid/in_ready : operand handshake, a/b carry the operands
//   out_valid/out_ready : result handshake, gt/lt/eq carry the result
//   busy : comparator is not idle
// modport master : producer/consumer side (testbench or system)
// modport slave  : comparator side
// -----------------------------------------------------------------------------
interface serial_comparator_if #(
   parameter int N_WIDTH = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [N_WIDTH-1:0] a;
   logic [N_WIDTH-1:0] b;
   logic               out_valid;
   logic               out_ready;
   logic               gt;
   logic               lt;
   logic               eq;
   logic               busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, gt, lt, eq, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, gt, lt, eq, busy
   );
endinterface

// File: rtl/serial_cmp_bit_step.sv
// -----------------------------------------------------------------------------
// serial_cmp_bit_step
// One step of the MSB-first comparison: folds one bit pair into the running
// decision. Once a decision is made it is sticky.
//   a_bit_i, b_bit_i : current bit pair
//   is_msb_i         : bit pair is the sign position
//   dec_i / dec_o    : running decision in / updated decision out
// Parameter SIGNED : 1 = two's complement (sign bit weighs negative)
// -----------------------------------------------------------------------------
module serial_cmp_bit_step
   import serial_comparator_pkg::*;
#(
   parameter int SIGNED = 1
) (
   input  logic a_bit_i,
   input  logic b_bit_i,
   input  logic is_msb_i,
   input  dec_e dec_i,
   output dec_e dec_o
);

   // decision update for one bit pair
   always_comb begin
      dec_o = dec_i;
      if (dec_i != DEC_UNDEC) begin
         dec_o = dec_i;
      end else if (a_bit_i == b_bit_i) begin
         dec_o = DEC_UNDEC;
      end else if (is_msb_i && (SIGNED != 0)) begin
         // a set sign bit marks the negative, i.e. smaller, operand
         dec_o = a_bit_i ? DEC_LT : DEC_GT;
      end else begin
         dec_o = a_bit_i ? DEC_GT : DEC_LT;
      end
   end

endmodule

// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
// Bit-serial magnitude comparator: captures a/b, examines one bit pair per
// clock MSB first, then presents exactly one of gt/lt/eq with out_valid until
// the consumer accepts it.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_comparator_if.slave (in_valid/in_ready/a/b,
//           out_valid/out_ready/gt/lt/eq, busy)
// Parameters: N_WIDTH (operand width, >= 2), SIGNED (1 = two's complement)
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish at the first
// differing bit pair instead of always walking all N_WIDTH bits.
// -----------------------------------------------------------------------------
module serial_comparator
   import serial_comparator_pkg::*;
#(
   parameter int N_WIDTH = 4,
   parameter int SIGNED  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_comparator_if.slave  bus
);

   localparam int              IDX_W   = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N_WIDTH - 1);

   state_e             state_q, state_d;
   logic [N_WIDTH-1:0] a_q, a_d;
   logic [N_WIDTH-1:0] b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   dec_e               dec_q, dec_d;
   logic               out_valid_q, out_valid_d;
   logic [2:0]         flags_q, flags_d;   // {gt, lt, eq}
   dec_e               step_dec_s;
   logic               last_step_s;

   serial_cmp_bit_step #(
      .SIGNED (SIGNED)
   ) u_bit_step (
      .a_bit_i  (a_q[idx_q]),
      .b_bit_i  (b_q[idx_q]),
      .is_msb_i (idx_q == IDX_MSB),
      .dec_i    (dec_q),
      .dec_o    (step_dec_s)
   );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   // stop as soon as a decision exists; equal operands still reach bit 0
   assign last_step_s = (idx_q == '0) || (step_dec_s != DEC_UNDEC);
`else
   assign last_step_s = (idx_q == '0);
`endif

   // next-state and datapath control
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      dec_d       = dec_q;
      out_valid_d = out_valid_q;
      flags_d     = flags_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               idx_d   = IDX_MSB;
               dec_d   = DEC_UNDEC;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            dec_d = step_dec_s;
            if (last_step_s) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               flags_d     = dec_to_flags(step_dec_s);
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               flags_d     = 3'b000;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            flags_d     = 3'b000;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         dec_q       <= DEC_UNDEC;
         out_valid_q <= 1'b0;
         flags_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         dec_q       <= dec_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.gt        = flags_q[2];
   assign bus.lt        = flags_q[1];
   assign bus.eq        = flags_q[0];

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
// Drives a signed and an unsigned 4-bit comparator in lockstep with the same
// operands; expected {out_valid, gt, lt, eq} and latency are queued when a
// transaction is launched and popped when the result appears.
// -----------------------------------------------------------------------------
module tb_serial_comparator;

   typedef struct {
      logic [3:0] exp_s;   // {out_valid, gt, lt, eq} signed DUT
      logic [3:0] exp_u;   // same for unsigned DUT
      int         lat;
   } sb_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [3:0] a_r;
   logic [3:0] b_r;

   int n_vec;
   int n_err;
   sb_t sb_q[$];

   serial_comparator_if #(.N_WIDTH(4)) if_s ();
   serial_comparator_if #(.N_WIDTH(4)) if_u ();

   assign if_s.in_valid  = in_valid;
   assign if_s.a         = a_r;
   assign if_s.b         = b_r;
   assign if_s.out_ready = out_ready;
   assign if_u.in_valid  = in_valid;
   assign if_u.a         = a_r;
   assign if_u.b         = b_r;
   assign if_u.out_ready = out_ready;

   serial_comparator #(.N_WIDTH(4), .SIGNED(1)) u_dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_s)
   );

   serial_comparator #(.N_WIDTH(4), .SIGNED(0)) u_dut_u (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_flags(input logic [3:0] av, input logic [3:0] bv, input bit sgn);
      logic gt_v;
      logic lt_v;
      if (sgn) begin
         gt_v = ($signed(av) > $signed(bv));
         lt_v = ($signed(av) < $signed(bv));
      end else begin
         gt_v = (av > bv);
         lt_v = (av < bv);
      end
      return {1'b1, gt_v, lt_v, (av == bv)};
   endfunction

   function automatic int exp_lat(input logic [3:0] av, input logic [3:0] bv);
      int lat_v;
      logic [3:0] diff;
      lat_v = 4;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      diff = av ^ bv;
      for (int k = 0; k < 4; k++) begin
         if (diff[k]) lat_v = 4 - k;
      end
`else
      diff = 4'd0;
`endif
      return lat_v;
   endfunction

   function automatic sb_t make_exp(input logic [3:0] av, input logic [3:0] bv);
      sb_t e;
      e.exp_s = exp_flags(av, bv, 1'b1);
      e.exp_u = exp_flags(av, bv, 1'b0);
      e.lat   = exp_lat(av, bv);
      return e;
   endfunction

   // launch one transaction, return observed outputs when out_valid appears,
   // then complete the output handshake
   task automatic do_txn(input logic [3:0] av, input logic [3:0] bv,
                         output logic [3:0] obs_s, output logic [3:0] obs_u,
                         output int lat, output bit tmo);
      tmo = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if_s.in_ready && if_u.in_ready) begin
            tmo = 1'b0;
            break;
         end
      end
      in_valid  = 1'b1;
      a_r       = av;
      b_r       = bv;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_r      = 4'($urandom);
      b_r      = 4'($urandom);
      lat = 0;
      tmo = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (if_s.out_valid) begin
            tmo = 1'b0;
            break;
         end
      end
      obs_s = {if_s.out_valid, if_s.gt, if_s.lt, if_s.eq};
      obs_u = {if_u.out_valid, if_u.gt, if_u.lt, if_u.eq};
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_vec++;
      if ({if_s.out_valid, if_s.gt, if_s.lt, if_s.eq, if_s.busy, if_s.in_ready} !== 6'b000001) begin
         n_err++;
         $display("FAIL reset_s: got %b want 000001",
                  {if_s.out_valid, if_s.gt, if_s.lt, if_s.eq, if_s.busy, if_s.in_ready});
      end
      n_vec++;
      if ({if_u.out_valid, if_u.gt, if_u.lt, if_u.eq, if_u.busy, if_u.in_ready} !== 6'b000001) begin
         n_err++;
         $display("FAIL reset_u: got %b want 000001",
                  {if_u.out_valid, if_u.gt, if_u.lt, if_u.eq, if_u.busy, if_u.in_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [3:0] av_t[6] = '{4'b1000, 4'd5, 4'd8, 4'd7, 4'hF, 4'd3};
      logic [3:0] bv_t[6] = '{4'b0111, 4'd5, 4'd0, 4'd8, 4'h0, 4'd2};
      logic [3:0] obs_s, obs_u;
      int lat;
      bit tmo;
      sb_t e;
      for (int i = 0; i < 6; i++) begin
         sb_q.push_back(make_exp(av_t[i], bv_t[i]));
         do_txn(av_t[i], bv_t[i], obs_s, obs_u, lat, tmo);
         e = sb_q.pop_front();
         n_vec++;
         if (tmo) begin
            n_err++;
            $display("FAIL dir_timeout: a=%h b=%h no out_valid within bound", av_t[i], bv_t[i]);
         end
         n_vec++;
         if (obs_s !== e.exp_s) begin
            n_err++;
            $display("FAIL dir_signed: a=%h b=%h got %b want %b", av_t[i], bv_t[i], obs_s, e.exp_s);
         end
         n_vec++;
         if (obs_u !== e.exp_u) begin
            n_err++;
            $display("FAIL dir_unsigned: a=%h b=%h got %b want %b", av_t[i], bv_t[i], obs_u, e.exp_u);
         end
         n_vec++;
         if (lat !== e.lat) begin
            n_err++;
            $display("FAIL dir_latency: a=%h b=%h got %0d want %0d", av_t[i], bv_t[i], lat, e.lat);
         end
         @(negedge clk);
         n_vec++;
         if ({if_s.out_valid, if_s.gt, if_s.lt, if_s.eq, if_s.in_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL dir_idle_after: got %b want 00001",
                     {if_s.out_valid, if_s.gt, if_s.lt, if_s.eq, if_s.in_ready});
         end
      end
   endtask

   task automatic test_backpressure();
      sb_t e;
      bit seen;
      e = make_exp(4'd2, 4'd9);
      sb_q.push_back(e);
      @(negedge clk);
      in_valid  = 1'b1;
      a_r       = 4'd2;
      b_r       = 4'd9;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      a_r = 4'd9;
      b_r = 4'd2;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if_s.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      e = sb_q.pop_front();
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL bp_timeout: no out_valid within bound");
      end
      // offer new operands while the result is held; none may be taken
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_vec++;
         if ({if_s.out_valid, if_s.gt, if_s.lt, if_s.eq} !== e.exp_s || if_s.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold_s: cyc %0d got %b rdy %b want %b rdy 0",
                     i, {if_s.out_valid, if_s.gt, if_s.lt, if_s.eq}, if_s.in_ready, e.exp_s);
         end
         n_vec++;
         if ({if_u.out_valid, if_u.gt, if_u.lt, if_u.eq} !== e.exp_u || if_u.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold_u: cyc %0d got %b rdy %b want %b rdy 0",
                     i, {if_u.out_valid, if_u.gt, if_u.lt, if_u.eq}, if_u.in_ready, e.exp_u);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_vec++;
      if ({if_s.out_valid, if_s.busy, if_s.in_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL bp_release: got vld/busy/rdy %b want 001",
                  {if_s.out_valid, if_s.busy, if_s.in_ready});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [3:0] obs_s, obs_u;
      int lat;
      bit tmo;
      sb_t e;
      bit leaked;
      @(negedge clk);
      in_valid = 1'b1;
      a_r      = 4'd5;
      b_r      = 4'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({if_s.out_valid, if_s.busy, if_s.in_ready, if_u.out_valid, if_u.in_ready} !== 5'b00101) begin
         n_err++;
         $display("FAIL rst_mid: got %b want 00101",
                  {if_s.out_valid, if_s.busy, if_s.in_ready, if_u.out_valid, if_u.in_ready});
      end
      #2;
      rst_n = 1'b1;
      leaked = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (if_s.out_valid || if_u.out_valid) leaked = 1'b1;
      end
      n_vec++;
      if (leaked) begin
         n_err++;
         $display("FAIL rst_mid_leak: got out_valid 1 want 0 after reset");
      end
      sb_q.push_back(make_exp(4'd6, 4'hB));
      do_txn(4'd6, 4'hB, obs_s, obs_u, lat, tmo);
      e = sb_q.pop_front();
      n_vec++;
      if (tmo || obs_s !== e.exp_s || obs_u !== e.exp_u || lat !== e.lat) begin
         n_err++;
         $display("FAIL rst_mid_next: got s=%b u=%b lat=%0d tmo=%b want s=%b u=%b lat=%0d",
                  obs_s, obs_u, lat, tmo, e.exp_s, e.exp_u, e.lat);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] obs_s, obs_u;
      int lat;
      bit tmo;
      sb_t e;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            sb_q.push_back(make_exp(4'(ia), 4'(ib)));
            do_txn(4'(ia), 4'(ib), obs_s, obs_u, lat, tmo);
            e = sb_q.pop_front();
            n_vec++;
            if (tmo || obs_s !== e.exp_s) begin
               n_err++;
               $display("FAIL sweep_signed: a=%h b=%h got %b tmo=%b want %b", ia[3:0], ib[3:0], obs_s, tmo, e.exp_s);
            end
            n_vec++;
            if (obs_u !== e.exp_u) begin
               n_err++;
               $display("FAIL sweep_unsigned: a=%h b=%h got %b want %b", ia[3:0], ib[3:0], obs_u, e.exp_u);
            end
            n_vec++;
            if (lat !== e.lat) begin
               n_err++;
               $display("FAIL sweep_latency: a=%h b=%h got %0d want %0d", ia[3:0], ib[3:0], lat, e.lat);
            end
         end
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_r       = 4'd0;
      b_r       = 4'd0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
